branch_predictor_unit: RTL

Successor to the combinational branch-predict generator. Owns the direction predictor and the BTB internally instead of taking them as inputs:
- gshare pattern history table (PHT) of 2-bit saturating counters
- speculative global history register (GHR) with mispredict recovery
- direct-mapped tagged BTB

Sits in the fetch stage. Gets a lookup per fetched instruction and returns a registered BranchPredict-equivalent one cycle later. Gets training updates from the branch resolution stage.

---
 rtl/branch_predictor_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor_unit.sv
// Fetch-stage branch predictor: gshare PHT, speculative GHR with recovery, direct-mapped BTB.
// Latency 1 cycle lookup->prediction; no backpressure, lookups/updates are ignored until ready.
module branch_predictor_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int PHT_ENTRIES = 256,
    parameter int GHR_WIDTH   = 8,
    parameter int BTB_ENTRIES = 64,
    parameter int USE_BTB     = 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    output logic                  ready,
    input  logic                  lookupValid,
    input  logic [ADDR_WIDTH-1:0] lookupPc,
    input  logic                  lookupIsBranch,
    output logic                  predValid,
    output logic                  predIsNextPcPredicted,
    output logic [ADDR_WIDTH-1:0] predNextPc,
    output logic                  predTaken,
    output logic [GHR_WIDTH-1:0]  predGhr,
    input  logic                  updValid,
    input  logic [ADDR_WIDTH-1:0] updPc,
    input  logic [GHR_WIDTH-1:0]  updGhr,
    input  logic                  updTaken,
    input  logic [ADDR_WIDTH-1:0] updTarget,
    input  logic                  updMispredict
);
    localparam int PHT_IW = $clog2(PHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = ADDR_WIDTH - BTB_IW - 2;
    localparam int INIT_N = (PHT_ENTRIES > BTB_ENTRIES) ? PHT_ENTRIES : BTB_ENTRIES;
    localparam int CNT_W  = $clog2(INIT_N);

    typedef enum logic {INIT, READY} state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        init_idx_q;
    logic [GHR_WIDTH-1:0]    ghr_q, ghr_d;
    logic                    ready_q;
    logic                    pred_vld_q, pred_isnp_q, pred_taken_q;
    logic [ADDR_WIDTH-1:0]   pred_np_q;
    logic [GHR_WIDTH-1:0]    pred_ghr_q;

    logic [1:0]              pht_q     [PHT_ENTRIES];
    logic                    btb_vld_q [BTB_ENTRIES];
    logic [TAG_W-1:0]        btb_tag_q [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0]   btb_tgt_q [BTB_ENTRIES];

    logic                    active, lk_fire, upd_fire;
    logic [PHT_IW-1:0]       lk_pht_idx, upd_pht_idx;
    logic [BTB_IW-1:0]       lk_btb_idx, upd_btb_idx;
    logic [TAG_W-1:0]        lk_tag, upd_tag;
    logic [1:0]              lk_ctr, upd_ctr, upd_ctr_d;
    logic                    lk_hit, lk_taken;

    assign active   = (state_q == READY);
    assign lk_fire  = active & lookupValid;
    assign upd_fire = active & updValid;

    // Arrays are read combinationally before the clock edge writes them: read-first.
    assign lk_pht_idx = lookupPc[PHT_IW+1:2] ^ PHT_IW'(ghr_q);
    assign lk_btb_idx = lookupPc[BTB_IW+1:2];
    assign lk_tag     = lookupPc[ADDR_WIDTH-1:BTB_IW+2];
    assign lk_ctr     = pht_q[lk_pht_idx];
    assign lk_hit     = (USE_BTB != 0) && btb_vld_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
    assign lk_taken   = lookupIsBranch & lk_ctr[1];

    assign upd_pht_idx = updPc[PHT_IW+1:2] ^ PHT_IW'(updGhr);
    assign upd_btb_idx = updPc[BTB_IW+1:2];
    assign upd_tag     = updPc[ADDR_WIDTH-1:BTB_IW+2];
    assign upd_ctr     = pht_q[upd_pht_idx];

    always_comb begin
        upd_ctr_d = upd_ctr;
        if (updTaken && upd_ctr != 2'b11) begin
            upd_ctr_d = upd_ctr + 2'b01;
        end else if (!updTaken && upd_ctr != 2'b00) begin
            upd_ctr_d = upd_ctr - 2'b01;
        end
    end

    // Mispredict recovery wins over the speculative shift of a same-cycle lookup.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_fire && updMispredict) begin
            ghr_d = {updGhr[GHR_WIDTH-2:0], updTaken};
        end else if (lk_fire && lookupIsBranch) begin
            ghr_d = {ghr_q[GHR_WIDTH-2:0], lk_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q      <= INIT;
            init_idx_q   <= '0;
            ghr_q        <= '0;
            ready_q      <= 1'b0;
            pred_vld_q   <= 1'b0;
            pred_isnp_q  <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_np_q    <= '0;
            pred_ghr_q   <= '0;
        end else begin
            ghr_q        <= ghr_d;
            pred_vld_q   <= lk_fire;
            pred_ghr_q   <= lk_fire ? ghr_q : '0;
            pred_taken_q <= lk_fire & lk_taken;
            pred_isnp_q  <= lk_fire & lookupIsBranch & (~lk_ctr[1] | lk_hit);
            pred_np_q    <= (lk_fire && lk_taken && lk_hit) ? btb_tgt_q[lk_btb_idx] : '0;
            case (state_q)
                INIT: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == CNT_W'(INIT_N - 1)) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstN && state_q == INIT) begin
            pht_q[init_idx_q[PHT_IW-1:0]]     <= 2'b01;
            btb_vld_q[init_idx_q[BTB_IW-1:0]] <= 1'b0;
        end else if (upd_fire) begin
            pht_q[upd_pht_idx] <= upd_ctr_d;
            if (updTaken) begin
                btb_vld_q[upd_btb_idx] <= 1'b1;
                btb_tag_q[upd_btb_idx] <= upd_tag;
                btb_tgt_q[upd_btb_idx] <= updTarget;
            end
        end
    end

    assign ready                 = ready_q;
    assign predValid             = pred_vld_q;
    assign predIsNextPcPredicted = pred_isnp_q;
    assign predNextPc            = pred_np_q;
    assign predTaken             = pred_taken_q;
    assign predGhr               = pred_ghr_q;
endmodule
